regfile_mp: RTL

Multi-ported, parametrised integer register file with a per-register pending-write scoreboard. It replaces the single-write, two-read register file in the RISC-V datapath, so a dual-issue or long-latency pipeline can read N operands, retire up to two results per cycle and detect RAW hazards. It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

---
 rtl/regfile_mp.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-ported integer register file.
//             - Two write ports, with port 1 winning on an address collision.
//             - NUM_RD_PORTS combinational read ports, with optional
//               same-cycle write forwarding.
//             - One pending-write bit per register, used by the pipeline to
//               detect read-after-write hazards.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int NUM_RD_PORTS  = 2,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [1:0]                           wr_en,
    input  logic [2*ADDRESS_WIDTH-1:0]           wr_addr,
    input  logic [2*DATA_WIDTH-1:0]              wr_data,
    input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD_PORTS-1:0]              rd_busy,
    input  logic                                 sb_set_en,
    input  logic [ADDRESS_WIDTH-1:0]             sb_set_addr,
    input  logic                                 sb_clr_on_wr
);

    // One extra bit so that NUM_REGS == 2**ADDRESS_WIDTH is representable.
    localparam logic [ADDRESS_WIDTH:0] c_num_regs = (ADDRESS_WIDTH+1)'(NUM_REGS);

    logic [1:0]            w_wr_ok;
    logic                  w_set_ok;
    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic                  w_pend [NUM_REGS];

    // An address is usable when it is in range and is not the hardwired zero.
    function automatic logic addr_usable(input logic [ADDRESS_WIDTH-1:0] addr);
        return ({1'b0, addr} < c_num_regs) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    // Qualify each write port: dropped when disabled, out of range or to reg 0.
    for (genvar p = 0; p < 2; p++) begin : g_wr
        assign w_wr_ok[p] = wr_en[p] && addr_usable(wr_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
    end

    assign w_set_ok = sb_set_en && addr_usable(sb_set_addr);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [ADDRESS_WIDTH-1:0] c_addr = ADDRESS_WIDTH'(i);

        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_pend;
        logic                  w_hit0;
        logic                  w_hit1;
        logic                  w_set;

        assign w_hit0 = w_wr_ok[0] && (wr_addr[0 +: ADDRESS_WIDTH] == c_addr);
        assign w_hit1 = w_wr_ok[1] && (wr_addr[ADDRESS_WIDTH +: ADDRESS_WIDTH] == c_addr);
        assign w_set  = w_set_ok && (sb_set_addr == c_addr);

        // Register storage: port 1 has priority over port 0 on a collision.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data <= '0;
            end else if (w_hit1) begin
                r_data <= wr_data[DATA_WIDTH +: DATA_WIDTH];
            end else if (w_hit0) begin
                r_data <= wr_data[0 +: DATA_WIDTH];
            end
        end

        // Pending bit: a new issue outranks the retirement of the older producer.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pend <= 1'b0;
            end else if (w_set) begin
                r_pend <= 1'b1;
            end else if (sb_clr_on_wr && (w_hit0 || w_hit1)) begin
                r_pend <= 1'b0;
            end
        end

        assign w_regs[i] = r_data;
        assign w_pend[i] = r_pend;
    end

    for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0]    w_data;
        logic                     w_busy;
        logic                     w_ok;
        logic                     w_hit0;
        logic                     w_hit1;
        logic                     w_clr;

        assign w_addr = rd_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign w_ok   = addr_usable(w_addr);
        assign w_hit0 = w_wr_ok[0] && (wr_addr[0 +: ADDRESS_WIDTH] == w_addr);
        assign w_hit1 = w_wr_ok[1] && (wr_addr[ADDRESS_WIDTH +: ADDRESS_WIDTH] == w_addr);
        // The write clears the pending bit only if no new issue lands on it.
        assign w_clr  = sb_clr_on_wr && (w_hit0 || w_hit1)
                        && !(w_set_ok && (sb_set_addr == w_addr));

        // Array lookup, then forwarding, then forced zero for reset / bad address.
        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_addr == ADDRESS_WIDTH'(i)) begin
                    w_data = w_regs[i];
                    w_busy = w_pend[i];
                end
            end
            if (BYPASS != 0) begin
                if (w_hit1) begin
                    w_data = wr_data[DATA_WIDTH +: DATA_WIDTH];
                end else if (w_hit0) begin
                    w_data = wr_data[0 +: DATA_WIDTH];
                end
                if (w_clr) begin
                    w_busy = 1'b0;
                end
            end
            if (!w_ok || rst) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign rd_busy[k]                          = w_busy;
    end

endmodule
`default_nettype wire
